cache_ctrl: RTL and testbench

Direct-mapped, write-through, read-allocate cache controller sitting directly upstream of the cache data array (1-cycle registered-read SRAM, `addr_width` index bits, `data_width` data bits). It accepts word requests from the CPU side, keeps tag and valid state in internal flops, drives the data array's read and write ports, and refills misses and posts writes to a backing memory over a valid/ready request channel. It handles one request at a time.

---
 rtl/cache_ctrl.sv | 155 +++++++++++++++
 tb/tb_cache_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_ctrl.sv
// Direct-mapped, write-through, read-allocate cache controller.
// Tag/valid live in flops; the data array is an external 1-cycle registered-read SRAM.
module cache_ctrl #(
  parameter int unsigned addr_width = 10,
  parameter int unsigned tag_width  = 6,
  parameter int unsigned data_width = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_we,
  input  logic [tag_width+addr_width-1:0] req_addr,
  input  logic [data_width-1:0]         req_wdata,
  output logic                          resp_valid,
  output logic [data_width-1:0]         resp_rdata,
  output logic                          arr_we,
  output logic [addr_width-1:0]         arr_waddr,
  output logic [data_width-1:0]         arr_wdata,
  output logic [addr_width-1:0]         arr_raddr,
  input  logic [data_width-1:0]         arr_rdata,
  output logic                          mem_req_valid,
  input  logic                          mem_req_ready,
  output logic                          mem_req_we,
  output logic [tag_width+addr_width-1:0] mem_req_addr,
  output logic [data_width-1:0]         mem_req_wdata,
  input  logic                          mem_resp_valid,
  input  logic [data_width-1:0]         mem_resp_rdata
);

  localparam int unsigned CW    = tag_width + addr_width;
  localparam int unsigned DEPTH = 2 ** addr_width;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_MISS_REQ,
    S_MISS_WAIT,
    S_WRITE_REQ
  } state_e;

  state_e                  state_q;
  logic                    live_q;
  logic                    we_q;
  logic [CW-1:0]           addr_q;
  logic [data_width-1:0]   wdata_q;
  logic [DEPTH-1:0]        valid_q;
  logic [tag_width-1:0]    tag_q [DEPTH];

  logic [addr_width-1:0]   idx;
  logic [tag_width-1:0]    ctag;
  logic                    hit;
  logic                    refill;

  assign idx    = addr_q[addr_width-1:0];
  assign ctag   = addr_q[CW-1:addr_width];
  assign hit    = valid_q[idx] && (tag_q[idx] == ctag);
  assign refill = (state_q == S_MISS_WAIT) && mem_resp_valid;

  // live_q holds req_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      live_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      valid_q <= '0;
    end else begin
      live_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (live_q && req_valid) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            state_q <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (we_q)     state_q <= S_WRITE_REQ;
          else if (hit) state_q <= S_IDLE;
          else          state_q <= S_MISS_REQ;
        end
        S_MISS_REQ: begin
          if (mem_req_ready) state_q <= S_MISS_WAIT;
        end
        S_MISS_WAIT: begin
          if (mem_resp_valid) begin
            valid_q[idx] <= 1'b1;
            state_q      <= S_IDLE;
          end
        end
        S_WRITE_REQ: begin
          if (mem_req_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Tags need no reset: a line is only trusted once its valid bit is set.
  always_ff @(posedge clk) begin
    if (refill) tag_q[idx] <= ctag;
  end

  always_comb begin
    req_ready     = 1'b0;
    resp_valid    = 1'b0;
    resp_rdata    = '0;
    arr_we        = 1'b0;
    arr_wdata     = '0;
    arr_raddr     = idx;
    mem_req_valid = 1'b0;
    mem_req_we    = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = live_q;
        arr_raddr = live_q ? req_addr[addr_width-1:0] : '0;
      end
      S_LOOKUP: begin
        if (hit && !we_q) begin
          resp_valid = 1'b1;
          resp_rdata = arr_rdata;
        end
        if (hit && we_q) begin
          arr_we    = 1'b1;
          arr_wdata = wdata_q;
        end
      end
      S_MISS_REQ: begin
        mem_req_valid = 1'b1;
      end
      S_MISS_WAIT: begin
        if (mem_resp_valid) begin
          arr_we     = 1'b1;
          arr_wdata  = mem_resp_rdata;
          resp_valid = 1'b1;
          resp_rdata = mem_resp_rdata;
        end
      end
      S_WRITE_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_we    = 1'b1;
        resp_valid    = mem_req_ready;
      end
      default: ;
    endcase
  end

  assign arr_waddr     = idx;
  assign mem_req_addr  = addr_q;
  assign mem_req_wdata = wdata_q;

endmodule

// File: tb/tb_cache_ctrl.sv
// Self-checking bench for cache_ctrl: directed scenarios plus randomized traffic
// against a reference model of the cache's hit/miss behaviour and backing memory contents.
module tb_cache_ctrl;

  localparam int unsigned AW = 10;
  localparam int unsigned TW = 6;
  localparam int unsigned DW = 64;
  localparam int unsigned CW = TW + AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [CW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          resp_valid;
  logic [DW-1:0] resp_rdata;
  logic          arr_we;
  logic [AW-1:0] arr_waddr;
  logic [DW-1:0] arr_wdata;
  logic [AW-1:0] arr_raddr;
  logic [DW-1:0] arr_rdata;
  logic          mem_req_valid;
  logic          mem_req_ready = 1'b0;
  logic          mem_req_we;
  logic [CW-1:0] mem_req_addr;
  logic [DW-1:0] mem_req_wdata;
  logic          mem_resp_valid = 1'b0;
  logic [DW-1:0] mem_resp_rdata = '0;

  always #5 clk = ~clk;

  cache_ctrl #(.addr_width(AW), .tag_width(TW), .data_width(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .arr_we(arr_we), .arr_waddr(arr_waddr), .arr_wdata(arr_wdata),
    .arr_raddr(arr_raddr), .arr_rdata(arr_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata)
  );

  // Data array: 1-cycle registered-read SRAM.
  logic [DW-1:0] sram [1<<AW];
  always @(posedge clk) begin
    if (arr_we) sram[arr_waddr] <= arr_wdata;
    arr_rdata <= sram[arr_raddr];
  end

  // Reference: backing memory contents and the cache's valid/tag directory.
  logic [DW-1:0] bmem [logic [CW-1:0]];
  bit            ref_valid [1<<AW];
  logic [TW-1:0] ref_tag   [1<<AW];

  int total = 0;
  int bad   = 0;

  function automatic logic [DW-1:0] mem_rd(input logic [CW-1:0] a);
    if (bmem.exists(a)) return bmem[a];
    return {16'hC0DE, a, ~{16'h0, a}};
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 64'(req_ready), 0);
    check({tag, "_resp_valid"}, 64'(resp_valid), 0);
    check({tag, "_arr_we"}, 64'(arr_we), 0);
    check({tag, "_mem_req_valid"}, 64'(mem_req_valid), 0);
    check({tag, "_mem_req_we"}, 64'(mem_req_we), 0);
    check({tag, "_resp_rdata"}, resp_rdata, 0);
    check({tag, "_arr_wdata"}, arr_wdata, 0);
    check({tag, "_mem_req_wdata"}, mem_req_wdata, 0);
    check({tag, "_mem_req_addr"}, 64'(mem_req_addr), 0);
    check({tag, "_arr_waddr"}, 64'(arr_waddr), 0);
    check({tag, "_arr_raddr"}, 64'(arr_raddr), 0);
  endtask

  // Issues one request and plays the backing memory until the response arrives.
  task automatic do_req(input bit we, input logic [CW-1:0] a, input logic [DW-1:0] wd, input int hold);
    logic [AW-1:0] idx;
    bit            hit, pend, pv, pr, pwe;
    int            cyc, first_mv, resp_cyc, n_mrd, n_mwr, n_awe, dly, guard, hold_left;
    logic [CW-1:0] paddr, hs_addr;
    logic [DW-1:0] pwd, hs_wd, rdat;
    idx = a[AW-1:0];
    hit = ref_valid[idx] && (ref_tag[idx] == a[CW-1:AW]);
    guard = 0;
    @(negedge clk); #1;
    while (!req_ready && guard < 20) begin
      @(negedge clk); #1;
      guard++;
    end
    if (!req_ready) begin
      check("ready_timeout", 0, 1);
      return;
    end
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd;
    cyc = 0; first_mv = -1; resp_cyc = -1; n_mrd = 0; n_mwr = 0; n_awe = 0;
    pend = 0; dly = 0; pv = 0; pr = 0; pwe = 0; paddr = '0; pwd = '0;
    hs_addr = '0; hs_wd = '0; rdat = '0; hold_left = hold;
    while (resp_cyc < 0 && cyc < 80) begin
      @(negedge clk);
      cyc++;
      req_valid = 1'b0; req_we = 1'($urandom); req_addr = CW'($urandom);
      req_wdata = {$urandom, $urandom};
      if (mem_req_valid && hold_left > 0) begin
        mem_req_ready = 1'b0;
        hold_left--;
      end else begin
        mem_req_ready = ($urandom_range(0, 2) != 0);
      end
      mem_resp_valid = 1'b0;
      mem_resp_rdata = {$urandom, $urandom};
      if (pend) begin
        if (dly == 0) begin
          mem_resp_valid = 1'b1;
          mem_resp_rdata = mem_rd(a);
          pend = 0;
        end else dly--;
      end else if (n_mrd == 0 && $urandom_range(0, 4) == 0) begin
        mem_resp_valid = 1'b1;  // stray response, must be ignored
      end
      #1;
      check("busy_ready", 64'(req_ready), 0);
      if (mem_req_valid) begin
        if (first_mv < 0) first_mv = cyc;
        if (pv && !pr) begin
          check("stable_addr", 64'(mem_req_addr), 64'(paddr));
          check("stable_we", 64'(mem_req_we), 64'(pwe));
          check("stable_wdata", mem_req_wdata, pwd);
        end
        if (mem_req_ready) begin
          hs_addr = mem_req_addr;
          hs_wd   = mem_req_wdata;
          if (mem_req_we) n_mwr++;
          else begin
            n_mrd++;
            pend = 1;
            dly  = $urandom_range(0, 3);
          end
        end
      end
      pv = mem_req_valid; pr = mem_req_ready; pwe = mem_req_we;
      paddr = mem_req_addr; pwd = mem_req_wdata;
      if (arr_we) begin
        n_awe++;
        check("arr_waddr", 64'(arr_waddr), 64'(idx));
      end
      if (resp_valid) begin
        resp_cyc = cyc;
        rdat = resp_rdata;
      end
    end
    if (resp_cyc < 0) begin
      check("resp_timeout", 0, 1);
    end else if (we) begin
      check("w_rdata", rdat, 0);
      check("w_mem_writes", 64'(n_mwr), 1);
      check("w_mem_reads", 64'(n_mrd), 0);
      check("w_addr", 64'(hs_addr), 64'(a));
      check("w_data", hs_wd, wd);
      check("w_arr_we", 64'(n_awe), hit ? 64'd1 : 64'd0);
      check("w_mreq_lat", 64'(first_mv), 2);
      bmem[a] = wd;
    end else begin
      check("r_data", rdat, mem_rd(a));
      check("r_mem_writes", 64'(n_mwr), 0);
      check("r_mem_reads", 64'(n_mrd), hit ? 64'd0 : 64'd1);
      check("r_arr_we", 64'(n_awe), hit ? 64'd0 : 64'd1);
      if (hit) begin
        check("r_hit_lat", 64'(resp_cyc), 1);
      end else begin
        check("r_mreq_lat", 64'(first_mv), 2);
        check("r_addr", 64'(hs_addr), 64'(a));
        ref_valid[idx] = 1'b1;
        ref_tag[idx]   = a[CW-1:AW];
      end
    end
    @(negedge clk);
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    #1;
    check("one_pulse", 64'(resp_valid), 0);
    check("idle_ready", 64'(req_ready), 1);
  endtask

  task automatic abort_in_miss_wait(input logic [CW-1:0] a);
    bit got_hs;
    got_hs = 0;
    @(negedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = a;
    for (int i = 0; i < 10 && !got_hs; i++) begin
      @(negedge clk);
      req_valid = 1'b0;
      mem_req_ready = 1'b1;
      #1;
      if (mem_req_valid && !mem_req_we) got_hs = 1;
    end
    check("abort_handshake", 64'(got_hs), 1);
    @(negedge clk);
    mem_req_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort_rst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < (1 << AW); i++) ref_valid[i] = 1'b0;
    #1;
    check("abort_ready_pre_edge", 64'(req_ready), 0);
    @(negedge clk);
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    #1;
    check("late_resp_valid", 64'(resp_valid), 0);
    check("late_arr_we", 64'(arr_we), 0);
    check("abort_ready_post", 64'(req_ready), 1);
    @(negedge clk);
    mem_resp_valid = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [AW-1:0] pool [5];
    logic [CW-1:0] ra;
    pool[0] = 10'h040; pool[1] = 10'h123; pool[2] = 10'h3FF;
    pool[3] = 10'h000; pool[4] = 10'h2A5;
    for (int i = 0; i < (1 << AW); i++) ref_valid[i] = 1'b0;

    // Garbage on inputs during reset must not leak to the outputs.
    req_valid = 1'b1; req_addr = 16'h1234; req_we = 1'b1; req_wdata = '1;
    mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_resp_rdata = '1;
    #22;
    check_reset_outputs("rst");
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
    rst_n = 1'b1;
    #1;
    check("ready_before_edge", 64'(req_ready), 0);
    @(posedge clk); #1;
    check("ready_after_edge", 64'(req_ready), 1);

    bmem[16'h0040] = 64'hDEADBEEF_00000001;
    do_req(0, 16'h0040, '0, 0);
    do_req(0, 16'h0040, '0, 0);
    do_req(0, 16'h0440, '0, 0);
    do_req(0, 16'h0040, '0, 0);
    do_req(1, 16'h0040, 64'h1111, 0);
    do_req(0, 16'h0040, '0, 0);
    do_req(1, 16'h0123, 64'h2222_3333_4444_5555, 0);
    do_req(0, 16'h0123, '0, 0);
    do_req(0, 16'h0777, '0, 5);
    do_req(1, 16'h0777, 64'hA5A5, 5);
    do_req(0, 16'h0440, '0, 0);
    abort_in_miss_wait(16'h0040);
    do_req(0, 16'h0040, '0, 0);
    do_req(0, 16'h0040, '0, 0);

    for (int n = 0; n < 200; n++) begin
      ra = {TW'($urandom_range(0, 3)), pool[$urandom_range(0, 4)]};
      do_req(($urandom_range(0, 9) < 3), ra, {$urandom, $urandom}, $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
